data_bus_responder: RTL and testbench

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

---
 rtl/data_bus_responder.sv | 168 ++++++++++++++++
 tb/tb_data_bus_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Word-organised memory slave: byte/half/word loads and stores with a fixed number of wait states.
// Latency is req-sample + 1 + WAIT_CYCLES; no backpressure, inputs are ignored until the response cycle ends.
module data_bus_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        busWe,
    input  logic [31:0] addr,
    input  logic [31:0] wData,
    input  logic [1:0]  memSize,
    input  logic        memUnsigned,
    output logic [31:0] rData,
    output logic        ready,
    output logic        err
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_WAIT    = 2'd1;
    localparam logic [1:0]  S_RESP    = 2'd2;
    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // "cur" is the transaction being decided: live inputs in IDLE, latched copy afterwards
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [1:0]  cur_size;
    logic        cur_uns;
    logic        cur_bad;
    logic [31:0] rd_word;
    logic [31:0] ld_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        enter_resp;
    logic        commit;
    logic [AW-1:0] st_idx;
    logic [31:0] st_word;

    always_comb begin
        cur_we   = (state_q == S_IDLE) ? busWe       : we_q;
        cur_addr = (state_q == S_IDLE) ? addr        : addr_q;
        cur_size = (state_q == S_IDLE) ? memSize     : size_q;
        cur_uns  = (state_q == S_IDLE) ? memUnsigned : uns_q;

        cur_bad = (cur_size == 2'b11)
                | ((cur_size == 2'b01) & cur_addr[0])
                | ((cur_size == 2'b10) & (cur_addr[1:0] != 2'b00))
                | (cur_addr[31:2] >= DEPTH_LIM);

        rd_word = cur_bad ? 32'h0 : mem[cur_addr[AW+1:2]];
        ld_byte = rd_word[{cur_addr[1:0], 3'b000} +: 8];
        ld_half = rd_word[{cur_addr[1], 4'b0000} +: 16];
        case (cur_size)
            2'b00:   ld_val = {{24{~cur_uns & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{~cur_uns & ld_half[15]}}, ld_half};
            2'b10:   ld_val = rd_word;
            default: ld_val = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = busWe;
                    addr_d  = addr;
                    wdata_d = wData;
                    size_d  = memSize;
                    uns_d   = memUnsigned;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = enter_resp;
        err_d   = enter_resp & cur_bad;
        rdata_d = (enter_resp & ~cur_bad & ~cur_we) ? ld_val : rdata_q;
    end

    // Store merges into the old word at the edge that ends RESP; a reset on that edge cancels it
    always_comb begin
        commit  = (state_q == S_RESP) & we_q & ~err_q & ~reset;
        st_idx  = addr_q[AW+1:2];
        st_word = mem[st_idx];
        case (size_q)
            2'b00:   st_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   st_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: st_word = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[st_idx] <= st_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign rData = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed plus random checks of data_bus_responder against a word-array reference model.
module tb_data_bus_responder;

    localparam int DEPTH = 64;
    localparam int W     = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, req0;
    logic        busWe;
    logic [31:0] addr, wData;
    logic [1:0]  memSize;
    logic        memUnsigned;
    logic [31:0] rData, rd0;
    logic        ready, rdy0;
    logic        err, err0;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mm [DEPTH];
    logic [31:0] m_rd;

    data_bus_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req(req), .busWe(busWe), .addr(addr), .wData(wData),
        .memSize(memSize), .memUnsigned(memUnsigned), .rData(rData), .ready(ready), .err(err)
    );

    data_bus_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .busWe(busWe), .addr(addr), .wData(wData),
        .memSize(memSize), .memUnsigned(memUnsigned), .rData(rd0), .ready(rdy0), .err(err0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_bad(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
               || (a / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        logic [31:0] w, v;
        int sh;
        w  = mm[a / 4];
        sh = (a % 4) * 8;
        if (sz == 2'd2) return w;
        if (sz == 2'd0) begin
            v = (w >> sh) & 32'hFF;
            if (!u && v >= 128) v = v + 32'hFFFFFF00;
        end else begin
            v = (w >> sh) & 32'hFFFF;
            if (!u && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] mask;
        int sh;
        sh   = (a % 4) * 8;
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        mm[a / 4] = (mm[a / 4] & ~(mask << sh)) | ((wd & mask) << sh);
    endtask

    // Starts from one cycle into IDLE (#1 after an edge), returns one cycle after the response
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u, input string tag);
        bit bad;
        int lat;
        bit got;
        bad = m_bad(a, sz);
        if (!bad && !we) m_rd = m_load(a, sz, u);
        if (!bad && we) m_store(a, wd, sz);
        req = 1'b1; busWe = we; addr = a; wData = wd; memSize = sz; memUnsigned = u;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            req = 1'b0;
            lat++;
            if (ready === 1'b1) got = 1'b1;
        end
        chk({tag, " latency"}, 32'(lat), 32'(W + 1));
        chk({tag, " err"}, {31'b0, err}, {31'b0, bad});
        chk({tag, " rData"}, rData, m_rd);
        @(posedge clk); #1;
        chk({tag, " ready drop"}, {31'b0, ready}, 32'h0);
        chk({tag, " err idle"}, {31'b0, err}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; req0 = 1'b0; busWe = 1'b0; addr = 32'h0; wData = 32'h0;
        memSize = 2'd2; memUnsigned = 1'b0;
        m_rd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", {31'b0, ready}, 32'h0);
        chk("reset err", {31'b0, err}, 32'h0);
        chk("reset rData", rData, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 2'd2, 1'b0, "init");

        txn(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, "sw10");
        txn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, "lw10");
        chk("lw10 const", rData, 32'hDEADBEEF);

        txn(1'b1, 32'h20, 32'h00000000, 2'd2, 1'b0, "sw20");
        txn(1'b1, 32'h23, 32'h000000A5, 2'd0, 1'b0, "sb23");
        txn(1'b1, 32'h20, 32'h00008001, 2'd1, 1'b0, "sh20");
        txn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, "lw20");
        chk("lw20 const", rData, 32'hA5008001);
        txn(1'b0, 32'h23, 32'h0, 2'd0, 1'b0, "lb23");
        chk("lb23 const", rData, 32'hFFFFFFA5);
        txn(1'b0, 32'h23, 32'h0, 2'd0, 1'b1, "lbu23");
        chk("lbu23 const", rData, 32'h000000A5);
        txn(1'b0, 32'h20, 32'h0, 2'd1, 1'b0, "lh20");
        chk("lh20 const", rData, 32'hFFFF8001);
        txn(1'b0, 32'h20, 32'h0, 2'd1, 1'b1, "lhu20");
        chk("lhu20 const", rData, 32'h00008001);

        txn(1'b0, 32'h11, 32'h0, 2'd2, 1'b0, "lw11 err");
        chk("lw11 rData kept", rData, 32'h00008001);
        txn(1'b1, 32'h21, 32'h0000FFFF, 2'd1, 1'b0, "sh21 err");
        txn(1'b0, 32'h24, 32'h0, 2'd3, 1'b0, "size3 err");
        txn(1'b1, 32'(DEPTH * 4), 32'hCAFEF00D, 2'd2, 1'b0, "sw oob err");
        txn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, "lw20 after err");
        chk("lw20 unchanged", rData, 32'hA5008001);
        txn(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, "lw0 no alias");

        txn(1'b1, 32'h30, 32'h0, 2'd2, 1'b0, "sw30 zero");
        req = 1'b1; busWe = 1'b1; addr = 32'h30; wData = 32'h12345678; memSize = 2'd2;
        @(posedge clk); #1;
        req = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_rd = 32'h0;
        chk("abort ready", {31'b0, ready}, 32'h0);
        chk("abort err", {31'b0, err}, 32'h0);
        chk("abort rData", rData, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort quiet", {31'b0, ready}, 32'h0);
        end
        txn(1'b0, 32'h30, 32'h0, 2'd2, 1'b0, "lw30 after abort");
        chk("lw30 const", rData, 32'h00000000);

        for (int n = 0; n < 60; n++) begin
            txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH * 4 + 7)), $urandom,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd");
        end

        busWe = 1'b0; addr = 32'h0; memSize = 2'd2; memUnsigned = 1'b0;
        req0 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 3) req0 = 1'b0;
            chk("b2b ready", {31'b0, rdy0}, (k % 2 == 1) ? 32'h1 : 32'h0);
            chk("b2b err", {31'b0, err0}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
